// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: default widths and FSM state encoding.
package mem_loader_pkg;

  localparam int LDR_DATA_W = 16;
  localparam int LDR_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader_shadow_ram.sv
// Shadow copy of every word the loader writes, used as the reference during verify.
module shadow_ram
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = LDR_DATA_W,
  parameter int ADDR_W = LDR_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_loader.sv
// Streams words from an upstream source into the loader port of a memory,
// optionally reading them back and flagging the first mismatching address.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = LDR_DATA_W,
  parameter int ADDR_W = LDR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              verify_en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Tbornot,
  output logic [ADDR_W-1:0] Addr_tb,
  output logic [DATA_W-1:0] Data_tb,
  output logic              WE_tb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic              verify_q;
  logic              vpend_q;
  logic [DATA_W-1:0] shadow_rdata;
  logic              xfer;

  assign xfer    = (state == WRITE) && s_valid;
  assign s_ready = (state == WRITE);
  assign busy    = (state != IDLE);
  assign Tbornot = (state != IDLE);

  shadow_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shadow (
    .clk   (clk),
    .we    (xfer),
    .waddr (addr_q),
    .wdata (s_data),
    .raddr (Addr_tb),
    .rdata (shadow_rdata)
  );

  // In VERIFY the address is issued one cycle ahead; vpend_q marks that
  // Addr_tb holds a read whose data is due for comparison at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      verify_q <= 1'b0;
      vpend_q  <= 1'b0;
      Addr_tb  <= '0;
      Data_tb  <= '0;
      WE_tb    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      WE_tb <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            addr_q   <= base_addr;
            cnt_q    <= '0;
            len_q    <= (length > MAX_LEN) ? MAX_LEN : length;
            verify_q <= verify_en;
            vpend_q  <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            state    <= (length == '0) ? FINISH : WRITE;
          end
        end
        WRITE: begin
          if (s_valid) begin
            Addr_tb <= addr_q;
            Data_tb <= s_data;
            WE_tb   <= 1'b1;
            addr_q  <= addr_q + 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == len_q) begin
              addr_q  <= base_q;
              cnt_q   <= '0;
              vpend_q <= 1'b0;
              state   <= verify_q ? VERIFY : FINISH;
            end
          end
        end
        VERIFY: begin
          if (vpend_q && (mem_rdata != shadow_rdata) && !err) begin
            err      <= 1'b1;
            err_addr <= Addr_tb;
          end
          if (cnt_q != len_q) begin
            Addr_tb <= addr_q;
            addr_q  <= addr_q + 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            vpend_q <= 1'b1;
          end else begin
            vpend_q <= 1'b0;
            state   <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued at start and
// popped whenever the loader pulses WE_tb; a model memory answers verify reads.
module tb_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        verify_en;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] mem_rdata;
  logic        Tbornot;
  logic [7:0]  Addr_tb;
  logic [15:0] Data_tb;
  logic        WE_tb;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_addr;

  logic [15:0] model_mem [256];
  logic        corrupt;
  logic [23:0] exp_q [$];
  int          pass_cnt;
  int          total_cnt;
  int          we_seen;

  mem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .verify_en (verify_en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_rdata (mem_rdata),
    .Tbornot   (Tbornot),
    .Addr_tb   (Addr_tb),
    .Data_tb   (Data_tb),
    .WE_tb     (WE_tb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model memory clocked on the falling edge, with an optional faulty cell at 0x22.
  always @(negedge clk) begin
    if (Tbornot && WE_tb) model_mem[Addr_tb] = Data_tb;
  end
  assign mem_rdata = model_mem[Addr_tb] ^ ((corrupt && Addr_tb == 8'h22) ? 16'hFFFF : 16'h0000);

  task automatic sb_step();
    logic [23:0] e;
    if (WE_tb === 1'b1) begin
      we_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_write: got write addr=%h data=%h, required no write", Addr_tb, Data_tb);
      end else begin
        e = exp_q.pop_front();
        if ({Addr_tb, Data_tb} !== e)
          $display("[TB] FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h", Addr_tb, Data_tb, e[23:16], e[15:0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic start_load(input logic [7:0] b, input int len, input logic ven, input logic [15:0] seed);
    int n;
    n = (len > 256) ? 256 : len;
    for (int i = 0; i < n; i++) exp_q.push_back({b + 8'(i), seed + 16'(i)});
    base_addr = b;
    length    = 9'(len);
    verify_en = ven;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [15:0] seed, input bit gaps);
    int i;
    int slot;
    logic v;
    i = 0;
    slot = 0;
    while (i < n && slot < 2000) begin
      sb_step();
      v = gaps ? ((slot % 4) == 0 || (slot % 4) == 3) : 1'b1;
      s_valid = v;
      s_data  = seed + 16'(i);
      if (v && s_ready === 1'b1) i++;
      slot++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (i < n) begin
      total_cnt++;
      $display("[TB] FAIL send_timeout: got %0d words accepted, required %0d", i, n);
    end
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (cycles < bound) begin
      sb_step();
      if (done === 1'b1) break;
      @(negedge clk);
      cycles++;
    end
    total_cnt++;
    if (cycles >= bound) $display("[TB] FAIL done_timeout: got no done in %0d cycles, required done", bound);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    total_cnt++; if ({Tbornot, WE_tb, s_ready, busy, done, err} !== 6'b0) $display("[TB] FAIL reset_flags: got %b, required 000000", {Tbornot, WE_tb, s_ready, busy, done, err}); else pass_cnt++;
    total_cnt++; if ({Addr_tb, Data_tb, err_addr} !== 32'h0) $display("[TB] FAIL reset_buses: got %h, required 0", {Addr_tb, Data_tb, err_addr}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    int w0;
    w0 = we_seen;
    start_load(8'h10, 4, 1'b0, 16'h00A1);
    total_cnt++; if ({Tbornot, busy, s_ready} !== 3'b111) $display("[TB] FAIL basic_owned: got %b, required 111", {Tbornot, busy, s_ready}); else pass_cnt++;
    send_words(4, 16'h00A1, 1'b0);
    wait_done(20, cyc);
    // done lands one cycle after the last WE_tb pulse
    total_cnt++; if (cyc !== 1) $display("[TB] FAIL basic_done_lat: got %0d, required 1", cyc); else pass_cnt++;
    total_cnt++; if ({Tbornot, busy} !== 2'b00) $display("[TB] FAIL basic_release: got %b, required 00", {Tbornot, busy}); else pass_cnt++;
    @(negedge clk);
    sb_step();
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b, required 0", done); else pass_cnt++;
    total_cnt++; if (we_seen - w0 !== 4) $display("[TB] FAIL basic_we_count: got %0d, required 4", we_seen - w0); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int cyc;
    int w0;
    w0 = we_seen;
    start_load(8'hFE, 3, 1'b0, 16'h0B00);
    send_words(3, 16'h0B00, 1'b0);
    wait_done(20, cyc);
    @(negedge clk);
    total_cnt++; if (we_seen - w0 !== 3 || exp_q.size() !== 0) $display("[TB] FAIL wrap_count: got %0d writes %0d left, required 3 writes 0 left", we_seen - w0, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int cyc;
    int w0;
    w0 = we_seen;
    start_load(8'h30, 2, 1'b0, 16'h3C00);
    // a second start while busy must not redirect the load
    start = 1'b1;
    base_addr = 8'h70;
    send_words(2, 16'h3C00, 1'b1);
    start = 1'b0;
    wait_done(20, cyc);
    @(negedge clk);
    total_cnt++; if (we_seen - w0 !== 2) $display("[TB] FAIL bp_we_count: got %0d, required 2", we_seen - w0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL bp_idle: got busy=%b, required 0", busy); else pass_cnt++;
  endtask

  task automatic test_verify(input bit bad);
    int cyc;
    corrupt = bad;
    start_load(8'h20, 4, 1'b1, 16'h5A00);
    send_words(4, 16'h5A00, 1'b0);
    wait_done(40, cyc);
    total_cnt++; if (err !== bad) $display("[TB] FAIL verify_err: got %b, required %b", err, bad); else pass_cnt++;
    total_cnt++; if (err_addr !== (bad ? 8'h22 : 8'h00)) $display("[TB] FAIL verify_err_addr: got %h, required %h", err_addr, bad ? 8'h22 : 8'h00); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (err !== bad) $display("[TB] FAIL verify_err_sticky: got %b, required %b", err, bad); else pass_cnt++;
    corrupt = 1'b0;
  endtask

  task automatic test_len_zero();
    int cyc;
    int w0;
    w0 = we_seen;
    start_load(8'h44, 0, 1'b0, 16'h0000);
    total_cnt++; if (err !== 1'b0) $display("[TB] FAIL zero_err_clear: got %b, required 0", err); else pass_cnt++;
    wait_done(10, cyc);
    // done two cycles after the start cycle, i.e. one after start_load returns
    total_cnt++; if (cyc !== 1) $display("[TB] FAIL zero_done_lat: got %0d, required 1", cyc); else pass_cnt++;
    total_cnt++; if (we_seen - w0 !== 0) $display("[TB] FAIL zero_writes: got %0d, required 0", we_seen - w0); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_len_max();
    int cyc;
    int w0;
    w0 = we_seen;
    start_load(8'h00, 300, 1'b0, 16'h1000);
    send_words(256, 16'h1000, 1'b0);
    total_cnt++; if (s_ready !== 1'b0) $display("[TB] FAIL max_ready_drop: got %b, required 0", s_ready); else pass_cnt++;
    wait_done(20, cyc);
    @(negedge clk);
    total_cnt++; if (we_seen - w0 !== 256) $display("[TB] FAIL max_we_count: got %0d, required 256", we_seen - w0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_load(8'h40, 8, 1'b0, 16'h7700);
    send_words(2, 16'h7700, 1'b0);
    sb_step();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({Tbornot, WE_tb, s_ready, busy, done, err} !== 6'b0) $display("[TB] FAIL midrst_flags: got %b, required 000000", {Tbornot, WE_tb, s_ready, busy, done, err}); else pass_cnt++;
    total_cnt++; if ({Addr_tb, Data_tb} !== 24'h0) $display("[TB] FAIL midrst_buses: got %h, required 0", {Addr_tb, Data_tb}); else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(8'h50, 3, 1'b1, 16'h6600);
    send_words(3, 16'h6600, 1'b0);
    wait_done(40, cyc);
    total_cnt++; if (err !== 1'b0 || exp_q.size() !== 0) $display("[TB] FAIL midrst_fresh: got err=%b left=%0d, required err=0 left=0", err, exp_q.size()); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    we_seen   = 0;
    corrupt   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    verify_en = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_verify(1'b0);
    test_verify(1'b1);
    test_len_zero();
    test_len_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
